ram_delay_line: RTL and testbench

- Programmable circular-buffer delay line for the signal-generator datapath.
- Each accepted sample is written into an internal simple-dual-port RAM at a free-running write pointer. The sample written `delay` strobes earlier is read back in the same strobe.
- Adds what the plain dual-port RAM lacks: synchronous reset, address generation, a run-time delay, a delay=0 bypass, and fill tracking that flags when the output is a real, aged sample.

---
 rtl/sig_gen_pkg.sv | 9 +
 rtl/sdp_ram.sv | 30 +++
 rtl/ram_delay_line.sv | 80 ++++++++
 tb/tb_ram_delay_line.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sig_gen_pkg.sv
// Shared defaults and types for the signal-generator datapath.
package sig_gen_pkg;

  localparam int DEF_ADDRESS_WIDTH = 9;
  localparam int DEF_DATA_WIDTH    = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// A same-cycle read of the address being written returns undefined data.
module sdp_ram #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_addr] <= din;
  end

  // Registered read port; holds its value when rd is low.
  always_ff @(posedge clk) begin
    if (rd) dout <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_delay_line.sv
// Programmable circular-buffer delay line with delay=0 bypass and fill tracking.
module ram_delay_line
  import sig_gen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic                     primed
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [ADDRESS_WIDTH:0]   fill;
  logic [ADDRESS_WIDTH:0]   fill_next;
  logic                     strobe;
  logic                     bypass_q;
  logic [DATA_WIDTH-1:0]    din_q;
  logic [DATA_WIDTH-1:0]    ram_q;

  // Reset wins over en: a sample presented during reset is never written.
  assign strobe  = en & rst_n;
  assign rd_addr = wr_ptr - delay;

  // Saturating fill increment.
  always_comb begin
    fill_next = fill;
    if (fill != FULL) fill_next = fill + 1'b1;
  end

  sdp_ram #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr     (strobe),
    .wr_addr(wr_ptr),
    .din    (din),
    .rd     (strobe),
    .rd_addr(rd_addr),
    .dout   (ram_q)
  );

  // Pointer, fill, valid and bypass-select registers.
  // Reset selects the bypass path with a zeroed sample, so dout reads 0
  // without needing a reset on the RAM's read register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill       <= '0;
      primed     <= 1'b0;
      dout_valid <= 1'b0;
      bypass_q   <= 1'b1;
      din_q      <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        fill       <= fill_next;
        primed     <= (fill_next == FULL);
        dout_valid <= (fill >= {1'b0, delay});
        bypass_q   <= (delay == '0);
        din_q      <= din;
      end
    end
  end

  // Both sources are registers updated only on strobes, so dout holds between them.
  assign dout = bypass_q ? din_q : ram_q;

endmodule

// File: tb/tb_ram_delay_line.sv
// Scoreboard bench for ram_delay_line (DEPTH=16) with a queue-based history model.
module tb_ram_delay_line;
  import sig_gen_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] delay = '0;
  sample_t       din = '0;
  sample_t       dout;
  logic          dout_valid;
  logic          primed;

  ram_delay_line #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .delay     (delay),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  sample_t hist[$];      // most recent DEPTH samples since reset, oldest first
  sample_t exp_q[$];     // expected data of outputs that must be flagged valid
  int      nstrobes = 0;
  logic    primed_exp = 1'b0;
  logic    known = 1'b0;  // dout value is defined by the model
  sample_t exp_dout = '0;
  logic    mon_on = 1'b0;

  task automatic cyc(input logic r, input logic e, input int d, input int x);
    int idx;
    @(negedge clk);
    rst_n = r;
    en    = e;
    delay = AW'(d);
    din   = 8'(x);
    @(posedge clk);
    if (!r) begin
      hist.delete();
      nstrobes   = 0;
      primed_exp = 1'b0;
      known      = 1'b1;
      exp_dout   = '0;
    end else if (e) begin
      hist.push_back(8'(x));
      if (hist.size() > DEPTH) void'(hist.pop_front());
      idx = hist.size() - 1 - d;
      if (idx >= 0) begin
        exp_q.push_back(hist[idx]);
        exp_dout = hist[idx];
        known    = 1'b1;
      end else begin
        known = 1'b0;
      end
      nstrobes++;
      primed_exp = (nstrobes >= DEPTH);
    end
  endtask

  // Monitor: compares outputs mid-cycle against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      sample_t e;
      checks++;
      if (primed !== primed_exp) begin
        failures++;
        $display("FAIL primed t=%0t got=%b exp=%b", $time, primed, primed_exp);
      end
      if (known) begin
        checks++;
        if (dout !== exp_dout) begin
          failures++;
          $display("FAIL dout_value t=%0t got=%02h exp=%02h", $time, dout, exp_dout);
        end
      end
      if (dout_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_valid t=%0t got=1 exp=0 dout=%02h", $time, dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            failures++;
            $display("FAIL valid_data t=%0t got=%02h exp=%02h", $time, dout, e);
          end
        end
      end else if (dout_valid !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL valid_x t=%0t got=%b exp=0/1", $time, dout_valid);
      end
    end
  end

  initial begin
    int d;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    mon_on = 1'b1;
    // 1: delay 3, ramp
    for (int k = 1; k <= 20; k++) cyc(1, 1, 3, k);
    // 2: bypass
    cyc(1, 1, 0, 8'hA5);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // 3: max delay, wrap and priming
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 40; k++) cyc(1, 1, 15, k);
    // 4: gapped strobes, delay 2
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      cyc(1, 1, 2, 8'h40 + k);
      cyc(1, 0, 2, 8'hEE);
      cyc(1, 0, 2, 8'hEE);
    end
    // 5: delay change mid-stream
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(1, 1, 2, 8'h80 + k);
    for (int k = 10; k < 16; k++) cyc(1, 1, 12, 8'h80 + k);
    for (int k = 16; k < 20; k++) cyc(1, 1, 1, 8'h80 + k);
    // 6: reset while strobing, then delay 5
    cyc(0, 1, 5, 8'h77);
    for (int k = 0; k < 10; k++) cyc(1, 1, 5, 8'h10 + k);
    // random stream
    d = 3;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 199) == 0) cyc(0, $urandom_range(0, 1), d, $urandom);
      else cyc(1, ($urandom_range(0, 3) != 0), d, $urandom_range(0, 255));
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_valid got=0 exp=%0d outstanding", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
